// File: rtl/cmd_assembler_pkg.sv
// Shared types and constants for the UART command assembler.
// Holds the FSM state enum, command width and timeout default.
package uart_cmd_pkg;

    localparam int CMD_W       = 24;
    localparam int BYTE_W      = 8;
    localparam int TMO_DEFAULT = 52080;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2
    } state_e;

    function automatic int cnt_w(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/cmd_assembler_if.sv
// Byte-in / command-out bundle between UART receiver, assembler
// and command consumer.
interface cmd_assembler_if;
    import uart_cmd_pkg::*;

    logic [BYTE_W-1:0] rx_byte;
    logic              rx_rdy;
    logic              rx_rdy_clr;
    logic [CMD_W-1:0]  cmd;
    logic              cmd_rdy;
    logic              clr_cmd_rdy;
    logic              cmd_ovr;
    logic              cmd_tmo;

    modport slave (
        input  rx_byte,
        input  rx_rdy,
        input  clr_cmd_rdy,
        output rx_rdy_clr,
        output cmd,
        output cmd_rdy,
        output cmd_ovr,
        output cmd_tmo
    );

    modport master (
        output rx_byte,
        output rx_rdy,
        output clr_cmd_rdy,
        input  rx_rdy_clr,
        input  cmd,
        input  cmd_rdy,
        input  cmd_ovr,
        input  cmd_tmo
    );

endinterface

// File: rtl/cmd_assembler_tmr.sv
// Inter-byte timeout counter for the command assembler.
// Counts while en is high, restarts on clr.
module cmd_tmr
    import uart_cmd_pkg::*;
#(
    parameter int CYCLES = TMO_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = cnt_w(CYCLES);
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/cmd_assembler.sv
// Packs three received UART bytes into a 24-bit command.
// Define CMD_TIMEOUT_EN to discard partial commands after an idle gap.
module cmd_assembler
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TMO_DEFAULT
) (
    input logic            clk,
    input logic            rst_n,
    cmd_assembler_if.slave bus
);

    state_e            state_q;
    state_e            state_d;
    logic [BYTE_W-1:0] b0_q;
    logic [BYTE_W-1:0] b1_q;
    logic [CMD_W-1:0]  cmd_q;
    logic              rdy_q;
    logic              ovr_q;
    logic              rx_rdy_q;
    logic              cap;
    logic              done;
    logic              tmo;
    logic              expired;

    // Capture only on the rising edge of the level flag, so a slow
    // receiver holding rx_rdy high never yields a second capture.
    assign cap            = bus.rx_rdy & ~rx_rdy_q;
    assign bus.rx_rdy_clr = cap & rst_n;

    assign bus.cmd     = cmd_q;
    assign bus.cmd_rdy = rdy_q;
    assign bus.cmd_ovr = ovr_q;

`ifdef CMD_TIMEOUT_EN
    logic tmr_clr;
    logic tmr_en;
    logic tmo_q;

    assign tmr_en  = (state_q != WAIT_B0);
    assign tmr_clr = cap | ~tmr_en;

    cmd_tmr #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_tmr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= tmo;
        end
    end

    assign bus.cmd_tmo = tmo_q;
`else
    localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
    logic unused_tmo;

    assign expired     = 1'b0;
    assign unused_tmo  = tmo;
    assign bus.cmd_tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        tmo     = 1'b0;
        unique case (state_q)
            WAIT_B0: begin
                if (cap) state_d = WAIT_B1;
            end
            WAIT_B1: begin
                if (cap) begin
                    state_d = WAIT_B2;
                end else if (expired) begin
                    state_d = WAIT_B0;
                    tmo     = 1'b1;
                end
            end
            WAIT_B2: begin
                if (cap) begin
                    state_d = WAIT_B0;
                    done    = 1'b1;
                end else if (expired) begin
                    state_d = WAIT_B0;
                    tmo     = 1'b1;
                end
            end
            default: state_d = WAIT_B0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_B0;
            rx_rdy_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rx_rdy_q <= bus.rx_rdy;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b0_q  <= '0;
            b1_q  <= '0;
            cmd_q <= '0;
            rdy_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            if (cap && state_q == WAIT_B0) b0_q <= bus.rx_byte;
            if (cap && state_q == WAIT_B1) b1_q <= bus.rx_byte;
            if (done) cmd_q <= {b0_q, b1_q, bus.rx_byte};
            // A completion outranks a same-cycle consumer clear.
            if (done) begin
                rdy_q <= 1'b1;
            end else if (bus.clr_cmd_rdy) begin
                rdy_q <= 1'b0;
            end
            ovr_q <= done & rdy_q & ~bus.clr_cmd_rdy;
        end
    end

endmodule

// File: doc/cmd_assembler.md
CMD_ASSEMBLER -- requirements
Module: cmd_assembler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 52080, giving the inter-byte timeout in clk cycles (two byte-times at 2604 clk/bit).
REQ-002 SHALL have port clk, input, 1 bit: system clock, all flops on posedge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port rx_byte, input, 8 bits: received byte from the UART receiver, valid while rx_rdy=1.
REQ-005 SHALL have port rx_rdy, input, 1 bit: receiver byte-ready flag, level, held until cleared.
REQ-006 SHALL have port rx_rdy_clr, output, 1 bit: combinational clear strobe back to the receiver.
REQ-007 SHALL have port cmd, output, 24 bits: assembled command {byte0, byte1, byte2}, with byte0 in [23:16].
REQ-008 SHALL have port cmd_rdy, output, 1 bit: command-valid flag, level, held until cleared.
REQ-009 SHALL have port clr_cmd_rdy, input, 1 bit: consumer clear for cmd_rdy.
REQ-010 SHALL have port cmd_ovr, output, 1 bit: one-cycle pulse when a new command overwrites an unconsumed one.
REQ-011 SHALL have port cmd_tmo, output, 1 bit: one-cycle pulse when a partial command is discarded on timeout.

Function
REQ-012 SHALL implement the FSM states WAIT_B0, WAIT_B1 and WAIT_B2.
REQ-013 SHALL, in any state with rx_rdy=1, assert rx_rdy_clr combinationally in that same cycle.
REQ-014 SHALL, in that same rx_rdy=1 cycle, capture rx_byte into the slot for the current state on the next edge.
REQ-015 SHALL advance the FSM on each such capture: WAIT_B0 to WAIT_B1, WAIT_B1 to WAIT_B2, and WAIT_B2 to WAIT_B0.
REQ-016 SHALL never capture the same byte twice: rx_rdy_clr is asserted at most once per rx_rdy rising episode, and rx_rdy is low the cycle after the clear.
REQ-017 SHALL, on capture in WAIT_B2, load cmd={b0,b1,rx_byte} and set cmd_rdy=1 on the same edge, giving one-cycle latency from the last byte.
REQ-018 SHALL leave cmd unchanged between completions.
REQ-019 SHALL clear cmd_rdy on the edge after clr_cmd_rdy=1; if clr_cmd_rdy and a completion coincide, the set wins and cmd_rdy stays 1.
REQ-020 SHALL, when a completion occurs while cmd_rdy=1 and clr_cmd_rdy=0, overwrite cmd, keep cmd_rdy=1, and pulse cmd_ovr for one cycle.
REQ-021 SHALL not assert cmd_rdy, cmd_ovr or cmd_tmo in response to a partial command (one or two bytes).
REQ-022 SHALL hold outputs in WAIT_B0 with no rx_rdy indefinitely, with no activity.

Reset
REQ-023 SHALL, on rst_n low, asynchronously force: FSM=WAIT_B0, cmd=24'h000000, cmd_rdy=0, cmd_ovr=0, cmd_tmo=0, byte slots=0, timeout counter=0.
REQ-024 SHALL drive rx_rdy_clr=0 during reset.
REQ-025 SHALL, on reset mid-command, discard partial bytes; the first byte after release is byte0.

Configuration
REQ-026 SHALL, with macro CMD_TIMEOUT_EN defined, run a counter in WAIT_B1/WAIT_B2 that clears on every capture and on entry to WAIT_B0.
REQ-027 SHALL, with CMD_TIMEOUT_EN defined and the counter at TIMEOUT_CYCLES-1 with no capture that cycle, go to WAIT_B0 and pulse cmd_tmo for one cycle.
REQ-028 SHALL, with CMD_TIMEOUT_EN defined and a capture coinciding with the terminal count, take the capture and not time out.
REQ-029 SHALL, without CMD_TIMEOUT_EN, instantiate no counter, tie cmd_tmo to 0, and wait for the next byte indefinitely.

Structure
REQ-030 SHALL take the state enum, CMD_W=24 and the TIMEOUT_CYCLES default from package uart_cmd_pkg.
REQ-031 SHALL place the timeout counter in sub-module cmd_tmr (inputs clr and en, output expired), instantiated only under CMD_TIMEOUT_EN.

Verification
REQ-032 Bench SHALL cover: bytes 8'hA5, 8'h3C, 8'h0F -> cmd=24'hA53C0F, cmd_rdy=1 one cycle after the third capture, three single-cycle rx_rdy_clr pulses.
REQ-033 Bench SHALL cover: rx_rdy held high 5 cycles per byte -> exactly one capture per byte; cmd correct.
REQ-034 Bench SHALL cover: two commands 24'h112233 then 24'h445566, no clr_cmd_rdy -> cmd=24'h445566, cmd_ovr one-cycle pulse, cmd_rdy stays 1.
REQ-035 Bench SHALL cover: clr_cmd_rdy coincident with third-byte capture -> cmd_rdy=1 afterward.
REQ-036 Bench SHALL cover: with CMD_TIMEOUT_EN, byte 8'h01 then idle TIMEOUT_CYCLES -> cmd_tmo pulse, then 8'hAA, 8'hBB, 8'hCC -> cmd=24'hAABBCC.
REQ-037 Bench SHALL cover: rst_n asserted after two bytes -> all outputs at reset values; the next three bytes form a complete command.
